// File: rtl/beam_scan_ctrl.sv
// beam_scan_ctrl: sweeps the beamformer steering index, measures |sample|
// energy per direction and locks onto the loudest direction.
module beam_scan_ctrl #(
    parameter int N_DIR          = 32,
    parameter int SEL_W          = 5,
    parameter int DATA_W         = 8,
    parameter int DWELL_SAMPLES  = 256,
    parameter int SETTLE_SAMPLES = 16,
    parameter int ACC_W          = DATA_W + $clog2(DWELL_SAMPLES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              scan_start,
    input  logic              manual_en,
    input  logic [SEL_W-1:0]  manual_sel,
    output logic [SEL_W-1:0]  delay_select,
    output logic              scan_busy,
    output logic              scan_done,
    output logic [SEL_W-1:0]  best_dir,
    output logic [ACC_W-1:0]  best_energy
);

    localparam int MAG_W   = DATA_W + 1;
    localparam int CNT_MAX = (DWELL_SAMPLES > SETTLE_SAMPLES) ?
                             DWELL_SAMPLES : SETTLE_SAMPLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [CNT_W-1:0] DW_LAST  = CNT_W'(DWELL_SAMPLES - 1);
    localparam logic [SEL_W-1:0] DIR_LAST = SEL_W'(N_DIR - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        MEASURE,
        COMPARE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] dir_idx_q, dir_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] run_best_q, run_best_d;
    logic [SEL_W-1:0] run_best_dir_q, run_best_dir_d;
    logic [SEL_W-1:0] best_dir_q, best_dir_d;
    logic [ACC_W-1:0] best_energy_q, best_energy_d;
    logic             locked_q, locked_d;
    logic [SEL_W-1:0] delay_select_q, delay_select_d;
    logic             scan_busy_q, scan_busy_d;
    logic             scan_done_q, scan_done_d;
    logic [MAG_W-1:0] mag;

    // Absolute value widened by one bit so the most negative sample does not wrap
    always_comb begin
        mag = {1'b0, sample};
        if (sample[DATA_W-1]) begin
            mag = {1'b0, ~sample} + MAG_W'(1);
        end
    end

    // Sweep FSM: settle, measure, compare per direction, then publish the winner
    always_comb begin
        state_d        = state_q;
        dir_idx_d      = dir_idx_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        run_best_d     = run_best_q;
        run_best_dir_d = run_best_dir_q;
        best_dir_d     = best_dir_q;
        best_energy_d  = best_energy_q;
        locked_d       = locked_q;
        scan_done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d        = SETTLE;
                    dir_idx_d      = '0;
                    cnt_d          = '0;
                    run_best_d     = '0;
                    run_best_dir_d = '0;
                end
            end
            SETTLE: begin
                if (sample_valid) begin
                    if (cnt_q == SET_LAST) begin
                        state_d = MEASURE;
                        cnt_d   = '0;
                        acc_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            MEASURE: begin
                if (sample_valid) begin
                    acc_d = acc_q + ACC_W'(mag);
                    if (cnt_q == DW_LAST) begin
                        state_d = COMPARE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMPARE: begin
                if (acc_q > run_best_q) begin
                    run_best_d     = acc_q;
                    run_best_dir_d = dir_idx_q;
                end
                if (dir_idx_q == DIR_LAST) begin
                    state_d       = DONE;
                    best_dir_d    = run_best_dir_d;
                    best_energy_d = run_best_d;
                    locked_d      = 1'b1;
                    scan_done_d   = 1'b1;
                end else begin
                    state_d   = SETTLE;
                    dir_idx_d = dir_idx_q + SEL_W'(1);
                    cnt_d     = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output selection: sweep index while busy, else manual or locked direction
    always_comb begin
        scan_busy_d    = (state_d != IDLE);
        delay_select_d = '0;
        if (state_q != IDLE) begin
            delay_select_d = dir_idx_q;
        end else if (manual_en) begin
            delay_select_d = manual_sel;
        end else if (locked_q) begin
            delay_select_d = best_dir_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            dir_idx_q      <= '0;
            cnt_q          <= '0;
            acc_q          <= '0;
            run_best_q     <= '0;
            run_best_dir_q <= '0;
            best_dir_q     <= '0;
            best_energy_q  <= '0;
            locked_q       <= 1'b0;
            delay_select_q <= '0;
            scan_busy_q    <= 1'b0;
            scan_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_idx_q      <= dir_idx_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            run_best_q     <= run_best_d;
            run_best_dir_q <= run_best_dir_d;
            best_dir_q     <= best_dir_d;
            best_energy_q  <= best_energy_d;
            locked_q       <= locked_d;
            delay_select_q <= delay_select_d;
            scan_busy_q    <= scan_busy_d;
            scan_done_q    <= scan_done_d;
        end
    end

    assign delay_select = delay_select_q;
    assign scan_busy    = scan_busy_q;
    assign scan_done    = scan_done_q;
    assign best_dir     = best_dir_q;
    assign best_energy  = best_energy_q;

endmodule

// File: tb/tb_beam_scan_ctrl.sv
// Testbench for beam_scan_ctrl: small-parameter instance driven from a vector
// table with a result scoreboard, plus a default-parameter instance.
module tb_beam_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Small instance: N_DIR=4, DWELL=4, SETTLE=2
    logic       s_valid = 0, s_start = 0, s_men = 0;
    logic [7:0] s_sample = 0;
    logic [4:0] s_msel = 0;
    logic [4:0] s_dsel, s_best_dir;
    logic       s_busy, s_done;
    logic [9:0] s_best_energy;

    beam_scan_ctrl #(
        .N_DIR(4), .SEL_W(5), .DATA_W(8),
        .DWELL_SAMPLES(4), .SETTLE_SAMPLES(2)
    ) u_small (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(s_valid), .sample(s_sample),
        .scan_start(s_start), .manual_en(s_men), .manual_sel(s_msel),
        .delay_select(s_dsel), .scan_busy(s_busy), .scan_done(s_done),
        .best_dir(s_best_dir), .best_energy(s_best_energy)
    );

    // Default instance
    logic        d_valid = 0, d_start = 0, d_men = 0;
    logic [7:0]  d_sample = 0;
    logic [4:0]  d_msel = 0;
    logic [4:0]  d_dsel, d_best_dir;
    logic        d_busy, d_done;
    logic [15:0] d_best_energy;

    beam_scan_ctrl u_dflt (
        .clk(clk), .rst_n(rst_n),
        .sample_valid(d_valid), .sample(d_sample),
        .scan_start(d_start), .manual_en(d_men), .manual_sel(d_msel),
        .delay_select(d_dsel), .scan_busy(d_busy), .scan_done(d_done),
        .best_dir(d_best_dir), .best_energy(d_best_energy)
    );

    typedef struct packed {
        logic [3:0][7:0] s;
        logic [3:0]      period;
        logic            restart;
        logic            idle_strb;
        logic [4:0]      exp_dir;
        logic [9:0]      exp_e;
    } vec_t;

    typedef struct {
        logic [4:0] dir;
        logic [9:0] energy;
        int         strobes;
    } exp_t;

    exp_t exp_q[$];
    int   s_strobes = 0;
    int   s_done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int s0, input int s1, input int s2,
                                input int s3, input int per, input bit rs,
                                input bit idl, input int ed, input int ee);
        vec_t v;
        v.s[0]      = 8'(s0);
        v.s[1]      = 8'(s1);
        v.s[2]      = 8'(s2);
        v.s[3]      = 8'(s3);
        v.period    = 4'(per);
        v.restart   = rs;
        v.idle_strb = idl;
        v.exp_dir   = 5'(ed);
        v.exp_e     = 10'(ee);
        return v;
    endfunction

    always @(posedge clk) begin
        if (s_valid) s_strobes++;
    end

    // Scoreboard: compare published result against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (s_done) begin
            s_done_cnt++;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_done", 0, 1);
            end else begin
                e = exp_q.pop_front();
                check("sb_best_dir", 32'(s_best_dir), 32'(e.dir));
                check("sb_best_energy", 32'(s_best_energy), 32'(e.energy));
                check("sb_strobes", s_strobes, e.strobes);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   dc0;
        int   n;
        dc0 = s_done_cnt;
        e.dir     = v.exp_dir;
        e.energy  = v.exp_e;
        e.strobes = s_strobes + 24;
        exp_q.push_back(e);
        s_start = 1;
        @(negedge clk);
        s_start = 0;
        for (int k = 0; k < 24; k++) begin
            s_valid  = 1;
            s_sample = v.s[k / 6];
            s_start  = v.restart && (k == 14);
            @(negedge clk);
            s_valid = 0;
            s_start = 0;
            for (int g = 1; g < int'(v.period); g++) @(negedge clk);
        end
        n = 0;
        while (s_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("busy_falls", 32'(s_busy), 0);
        @(negedge clk);
        check("done_pulses", s_done_cnt - dc0, 1);
        check("locked_dsel", 32'(s_dsel), 32'(v.exp_dir));
        check("sb_drained", exp_q.size(), 0);
    endtask

    vec_t vecs[5];
    int   cnt;
    int   dcnt;

    initial begin
        vecs[0] = mk(10, -20, 5, -128, 2, 0, 0, 3, 512);
        vecs[1] = mk(10, 20, -20, 10, 2, 0, 0, 1, 80);
        vecs[2] = mk(0, 0, 0, 0, 2, 0, 0, 0, 0);
        vecs[3] = mk(3, 7, 2, 1, 2, 1, 0, 1, 28);
        vecs[4] = mk(10, -20, 5, -128, 3, 0, 1, 3, 512);

        repeat (2) @(negedge clk);
        check("rst_s_dsel", 32'(s_dsel), 0);
        check("rst_s_busy", 32'(s_busy), 0);
        check("rst_s_done", 32'(s_done), 0);
        check("rst_s_best", 32'(s_best_dir), 0);
        check("rst_s_energy", 32'(s_best_energy), 0);
        rst_n = 1;
        @(negedge clk);
        check("rst_d_dsel", 32'(d_dsel), 0);
        check("rst_d_busy", 32'(d_busy), 0);

        // Reset in the middle of direction 5 measurement
        d_valid  = 1;
        d_sample = 8'h80;
        d_start  = 1;
        @(negedge clk);
        d_start = 0;
        repeat (5 * 273 + 16 + 50) @(negedge clk);
        check("mid_dsel", 32'(d_dsel), 5);
        check("mid_busy", 32'(d_busy), 1);
        #2 rst_n = 0;
        #1;
        check("arst_dsel", 32'(d_dsel), 0);
        check("arst_busy", 32'(d_busy), 0);
        check("arst_done", 32'(d_done), 0);
        check("arst_best", 32'(d_best_dir), 0);
        check("arst_energy", 32'(d_best_energy), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Full default sweep with constant -128
        d_start = 1;
        @(negedge clk);
        d_start = 0;
        cnt  = 0;
        dcnt = 0;
        while (d_busy && cnt < 10000) begin
            if (cnt == 1) check("restart_dir0", 32'(d_dsel), 0);
            if (d_done) dcnt++;
            cnt++;
            @(negedge clk);
        end
        d_valid = 0;
        check("dflt_busy_cycles", cnt, 32 * 272 + 32 + 1);
        check("dflt_done_pulses", dcnt, 1);
        check("dflt_best_dir", 32'(d_best_dir), 0);
        check("dflt_best_energy", 32'(d_best_energy), 32768);

        // Small-parameter vector table
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].idle_strb) begin
                for (int k = 0; k < 5; k++) begin
                    s_valid  = 1;
                    s_sample = 8'd100;
                    @(negedge clk);
                    s_valid = 0;
                    @(negedge clk);
                end
                check("idle_busy", 32'(s_busy), 0);
                check("idle_best", 32'(s_best_dir), 1);
                check("idle_energy", 32'(s_best_energy), 28);
                check("idle_dsel", 32'(s_dsel), 1);
            end
            run_vec(vecs[i]);
            if (vecs[i].restart) begin
                s_men  = 1;
                s_msel = 5'd7;
                @(negedge clk);
                check("manual_dsel", 32'(s_dsel), 7);
                s_men = 0;
                @(negedge clk);
                check("unmanual_dsel", 32'(s_dsel), 1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
